// File: rtl/rvfi_seq_record.sv
// rvfi_seq_record
// ---------------------------------------------------------------------------
// Trace recorder that turns an N-bit sampled signal plus its enable into an
// ASCII string using the same alphabet the formal sequence decoder consumes.
// This lets a recorded trace be pasted back as a sequence parameter.
// Enabled samples become lowercase hex digits; disabled samples become "x".
// The first recorded character is the most significant non-zero byte, which
// matches Verilog string-literal order.
//
// Build option:
//   RISCV_FORMAL_SEQ_RECORD_WRAP_EN
//     When defined, reaching LEN characters does not end recording. The
//     buffer keeps the most recent LEN samples. count saturates at LEN, and
//     the extra ovf output flags that at least one character was shifted out.
//
// Parameters:
//   N    sample width, 1..4
//   LEN  maximum characters held, 1..128
//
// Ports:
//   clock  in   rising-edge clock
//   reset  in   asynchronous active-low reset
//   start  in   clear the buffer and begin recording (wins over stop)
//   stop   in   append this cycle's sample, then finish
//   en     in   sample valid
//   din    in   sample value
//   seq    out  recorded string, newest character in bits [7:0]
//   count  out  number of characters held
//   busy   out  recording in progress
//   done   out  recording finished, buffer holds its contents
//   full   out  count == LEN
//   ovf    out  (wrap build only) oldest character has been discarded
// ---------------------------------------------------------------------------
module rvfi_seq_record #(
    parameter int N   = 4,
    parameter int LEN = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     en,
    input  logic [N-1:0]             din,
    output logic [8*LEN-1:0]         seq,
    output logic [$clog2(LEN+1)-1:0] count,
    output logic                     busy,
    output logic                     done,
    output logic                     full
`ifdef RISCV_FORMAL_SEQ_RECORD_WRAP_EN
    ,
    output logic                     ovf
`endif
);

    localparam int              CW    = $clog2(LEN + 1);
    localparam logic [CW-1:0]   LEN_C = CW'(LEN);

    generate
        if (N < 1 || N > 4 || LEN < 1 || LEN > 128) begin : g_param_check
            $error("rvfi_seq_record: N must be 1..4 and LEN must be 1..128");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECORD = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state_q;
    logic [8*LEN-1:0]  seq_q;
    logic [CW-1:0]     count_q;
    logic              busy_q;
    logic              done_q;
    logic              full_q;
`ifdef RISCV_FORMAL_SEQ_RECORD_WRAP_EN
    logic              ovf_q;
`endif

    logic [3:0]        din_ext_d;
    logic [7:0]        ch_d;
    logic [8*LEN-1:0]  seq_d;
    logic [CW-1:0]     count_d;
    logic              last_d;

    // Map a 4-bit value to its lowercase hex ASCII digit.
    function automatic logic [7:0] hex_char(input logic [3:0] v);
        if (v < 4'd10) begin
            return 8'h30 + {4'h0, v};
        end
        return 8'h57 + {4'h0, v};
    endfunction

    // Next buffer contents for a normal append. Shifting first and then
    // overwriting the low byte also works when LEN == 1.
    always_comb begin
        din_ext_d          = '0;
        din_ext_d[N-1:0]   = din;
        ch_d               = en ? hex_char(din_ext_d) : 8'h78;
        seq_d              = seq_q << 8;
        seq_d[7:0]         = ch_d;
`ifdef RISCV_FORMAL_SEQ_RECORD_WRAP_EN
        // Once the buffer is full the oldest char falls off the top, so count saturates.
        count_d            = (count_q == LEN_C) ? count_q : count_q + CW'(1);
        last_d             = 1'b0;
`else
        count_d            = count_q + CW'(1);
        last_d             = (count_d == LEN_C);
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            seq_q   <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            full_q  <= 1'b0;
`ifdef RISCV_FORMAL_SEQ_RECORD_WRAP_EN
            ovf_q   <= 1'b0;
`endif
        end else if (start) begin
            // start takes priority in every state. No sample is taken this cycle.
            state_q <= RECORD;
            seq_q   <= '0;
            count_q <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            full_q  <= 1'b0;
`ifdef RISCV_FORMAL_SEQ_RECORD_WRAP_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                RECORD: begin
                    seq_q   <= seq_d;
                    count_q <= count_d;
                    full_q  <= (count_d == LEN_C);
`ifdef RISCV_FORMAL_SEQ_RECORD_WRAP_EN
                    if (count_q == LEN_C) begin
                        ovf_q <= 1'b1;
                    end
`endif
                    if (stop || last_d) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE hold everything until the next start.
                end
            endcase
        end
    end

    assign seq   = seq_q;
    assign count = count_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign full  = full_q;
`ifdef RISCV_FORMAL_SEQ_RECORD_WRAP_EN
    assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_rvfi_seq_record.sv
// Bench for rvfi_seq_record. It drives two instances from shared stimulus:
//   A: N=4, LEN=4
//   B: N=2, LEN=8, driven by din[1:0]
// Both are checked every cycle against a character-list model of the recorder.
module tb_rvfi_seq_record;

    logic        clk;
    logic        reset;
    logic        start;
    logic        stop;
    logic        en;
    logic [3:0]  din;

    logic [31:0] seq_a;
    logic [2:0]  cnt_a;
    logic        busy_a, done_a, full_a;
    logic [63:0] seq_b;
    logic [3:0]  cnt_b;
    logic        busy_b, done_b, full_b;
`ifdef RISCV_FORMAL_SEQ_RECORD_WRAP_EN
    logic        ovf_a, ovf_b;
`endif

    rvfi_seq_record #(.N(4), .LEN(4)) u_a (
        .clock (clk),
        .reset (reset),
        .start (start),
        .stop  (stop),
        .en    (en),
        .din   (din),
        .seq   (seq_a),
        .count (cnt_a),
        .busy  (busy_a),
        .done  (done_a),
        .full  (full_a)
`ifdef RISCV_FORMAL_SEQ_RECORD_WRAP_EN
        ,
        .ovf   (ovf_a)
`endif
    );

    rvfi_seq_record #(.N(2), .LEN(8)) u_b (
        .clock (clk),
        .reset (reset),
        .start (start),
        .stop  (stop),
        .en    (en),
        .din   (din[1:0]),
        .seq   (seq_b),
        .count (cnt_b),
        .busy  (busy_b),
        .done  (done_b),
        .full  (full_b)
`ifdef RISCV_FORMAL_SEQ_RECORD_WRAP_EN
        ,
        .ovf   (ovf_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: 0 = idle, 1 = recording, 2 = finished.
    int         mst  [2];
    int         mcnt [2];
    bit         movf [2];
    logic [7:0] mq   [2][128];
    int         LENS [2] = '{4, 8};
    int         MASK [2] = '{15, 3};

    int nvec = 0;
    int nmis = 0;

    task automatic chk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mst[d]  = 0;
            mcnt[d] = 0;
            movf[d] = 1'b0;
        end
    endtask

    task automatic model_step(input int d);
        string      hx;
        logic [7:0] ch;
        int         v;
        hx = "0123456789abcdef";
        if (!reset) begin
            mst[d] = 0; mcnt[d] = 0; movf[d] = 1'b0;
            return;
        end
        if (start) begin
            mst[d] = 1; mcnt[d] = 0; movf[d] = 1'b0;
            return;
        end
        if (mst[d] != 1) return;
        v  = int'(din) & MASK[d];
        ch = en ? 8'(hx[v]) : 8'h78;
`ifdef RISCV_FORMAL_SEQ_RECORD_WRAP_EN
        if (mcnt[d] == LENS[d]) begin
            for (int i = 0; i < LENS[d] - 1; i++) mq[d][i] = mq[d][i+1];
            mq[d][LENS[d]-1] = ch;
            movf[d] = 1'b1;
        end else begin
            mq[d][mcnt[d]] = ch;
            mcnt[d]++;
        end
        if (stop) mst[d] = 2;
`else
        mq[d][mcnt[d]] = ch;
        mcnt[d]++;
        if (stop || mcnt[d] == LENS[d]) mst[d] = 2;
`endif
    endtask

    function automatic logic [1023:0] exp_seq(input int d);
        logic [1023:0] r;
        r = '0;
        for (int i = 0; i < mcnt[d]; i++) r = (r << 8) | 1024'(mq[d][i]);
        return r;
    endfunction

    task automatic compare_all();
        chk("A.seq",   1024'(seq_a),  exp_seq(0));
        chk("A.count", 1024'(cnt_a),  1024'(mcnt[0]));
        chk("A.busy",  1024'(busy_a), 1024'(mst[0] == 1));
        chk("A.done",  1024'(done_a), 1024'(mst[0] == 2));
        chk("A.full",  1024'(full_a), 1024'(mcnt[0] == LENS[0]));
        chk("B.seq",   1024'(seq_b),  exp_seq(1));
        chk("B.count", 1024'(cnt_b),  1024'(mcnt[1]));
        chk("B.busy",  1024'(busy_b), 1024'(mst[1] == 1));
        chk("B.done",  1024'(done_b), 1024'(mst[1] == 2));
        chk("B.full",  1024'(full_b), 1024'(mcnt[1] == LENS[1]));
`ifdef RISCV_FORMAL_SEQ_RECORD_WRAP_EN
        chk("A.ovf",   1024'(ovf_a),  1024'(movf[0]));
        chk("B.ovf",   1024'(ovf_b),  1024'(movf[1]));
`endif
    endtask

    // One clock: drive inputs after the falling edge, step the model on the
    // rising edge, then compare on the next falling edge.
    task automatic cyc(input bit s, input bit p, input bit e, input logic [3:0] d);
        start = s; stop = p; en = e; din = d;
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        compare_all();
    endtask

    // Pulse reset low between clock edges; outputs must clear without waiting for a clock.
    task automatic async_reset();
        #1 reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("rst.A.seq",   1024'(seq_a),  1024'(0));
        chk("rst.A.count", 1024'(cnt_a),  1024'(0));
        chk("rst.A.busy",  1024'(busy_a), 1024'(0));
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; stop = 1'b0; en = 1'b0; din = 4'h0;
        model_reset();
        @(negedge clk);
        cyc(0, 0, 1, 4'h5);
        cyc(1, 0, 1, 4'h5);
        chk("reset.seq",  1024'(seq_a),  1024'(0));
        chk("reset.busy", 1024'(busy_a), 1024'(0));
        chk("reset.done", 1024'(done_a), 1024'(0));
        chk("reset.full", 1024'(full_a), 1024'(0));
        reset = 1'b1;
        cyc(0, 0, 0, 4'h0);
        chk("idle.busy", 1024'(busy_a), 1024'(0));

        // "3ax" with stop on the final sample
        cyc(1, 0, 0, 4'h0);
        cyc(0, 0, 1, 4'h3);
        cyc(0, 0, 1, 4'ha);
        cyc(0, 1, 0, 4'h7);
        chk("3ax.seq",   1024'(seq_a),  1024'(32'h00336178));
        chk("3ax.count", 1024'(cnt_a),  1024'(3));
        chk("3ax.done",  1024'(done_a), 1024'(1));
        chk("3ax.busy",  1024'(busy_a), 1024'(0));
        chk("3ax.full",  1024'(full_a), 1024'(0));
        cyc(0, 1, 1, 4'h9);
        chk("3ax.hold",  1024'(seq_a),  1024'(32'h00336178));

        // Fill to LEN without stop
        cyc(1, 0, 0, 4'h0);
        for (int i = 1; i <= 4; i++) cyc(0, 0, 1, 4'(i));
`ifndef RISCV_FORMAL_SEQ_RECORD_WRAP_EN
        chk("fill.seq",   1024'(seq_a),  1024'(32'h31323334));
        chk("fill.count", 1024'(cnt_a),  1024'(4));
        chk("fill.full",  1024'(full_a), 1024'(1));
        chk("fill.done",  1024'(done_a), 1024'(1));
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 4'($urandom_range(0, 15)));
        chk("fill.hold",  1024'(seq_a),  1024'(32'h31323334));
`endif

        // Narrow instance: din zero-extended from 2 bits
        cyc(1, 0, 0, 4'h0);
        cyc(0, 0, 1, 4'h7);
        cyc(0, 1, 1, 4'h1);
        chk("narrow.B.seq", 1024'(seq_b), 1024'(64'h3331));
        chk("narrow.A.seq", 1024'(seq_a), 1024'(32'h3731));

        // Reset during recording after 2 samples
        cyc(1, 0, 0, 4'h0);
        cyc(0, 0, 1, 4'h2);
        cyc(0, 0, 0, 4'h2);
        async_reset();
        cyc(0, 0, 1, 4'h4);
        chk("postrst.busy", 1024'(busy_a), 1024'(0));

        // start and stop together while recording with count=2
        cyc(1, 0, 0, 4'h0);
        cyc(0, 0, 1, 4'hb);
        cyc(0, 0, 1, 4'hc);
        cyc(1, 1, 1, 4'hd);
        chk("ss.count", 1024'(cnt_a),  1024'(0));
        chk("ss.busy",  1024'(busy_a), 1024'(1));
        chk("ss.seq",   1024'(seq_a),  1024'(0));
        cyc(0, 0, 1, 4'he);
        chk("ss.cont",  1024'(seq_a),  1024'(32'h65));

`ifdef RISCV_FORMAL_SEQ_RECORD_WRAP_EN
        cyc(1, 0, 0, 4'h0);
        for (int i = 1; i <= 5; i++) cyc(0, 0, 1, 4'(i));
        cyc(0, 1, 1, 4'h6);
        chk("wrap.seq",   1024'(seq_a),  1024'(32'h33343536));
        chk("wrap.count", 1024'(cnt_a),  1024'(4));
        chk("wrap.full",  1024'(full_a), 1024'(1));
        chk("wrap.ovf",   1024'(ovf_a),  1024'(1));
        chk("wrap.done",  1024'(done_a), 1024'(1));
        cyc(1, 0, 0, 4'h0);
        chk("wrap.clrovf",  1024'(ovf_a),  1024'(0));
        chk("wrap.clrfull", 1024'(full_a), 1024'(0));
`endif

        // Randomized traffic
        for (int k = 0; k < 2000; k++) begin
            if (k % 257 == 200) async_reset();
            cyc($urandom_range(0, 15) == 0, $urandom_range(0, 11) == 0,
                $urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
